issue_station: RTL and testbench

- 4-entry reservation station that feeds the 4-input priority arbiter node.
- Holds dispatched micro-ops and captures operands from the common data bus (CDB).
- Raises one request per ready entry to the arbiter's R0..R3 and accepts its one-hot grant G0..G3.
- Moves the granted entry into a registered issue slot that drives one functional unit through a valid/ready handshake.

---
 rtl/issue_station.sv | 205 ++++++++++++++++++++
 tb/tb_issue_station.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_station.sv
// Four-entry reservation station: captures operands from the CDB, requests issue from an external
// priority arbiter and moves the granted entry into a valid/ready issue slot.
module issue_station #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned OP_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_dst_tag,
    input  logic [TAG_W-1:0]  disp_src1_tag,
    input  logic              disp_src1_rdy,
    input  logic [DATA_W-1:0] disp_src1_val,
    input  logic [TAG_W-1:0]  disp_src2_tag,
    input  logic              disp_src2_rdy,
    input  logic [DATA_W-1:0] disp_src2_val,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic [3:0]        req,
    input  logic [3:0]        grant,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [TAG_W-1:0]  iss_dst_tag,
    output logic [DATA_W-1:0] iss_src1,
    output logic [DATA_W-1:0] iss_src2,
    output logic [2:0]        count
);

    localparam int unsigned N = 4;

    logic [N-1:0]      valid_q, valid_d;
    logic [N-1:0]      s1_rdy_q, s1_rdy_d;
    logic [N-1:0]      s2_rdy_q, s2_rdy_d;
    logic [OP_W-1:0]   op_q      [N];
    logic [OP_W-1:0]   op_d      [N];
    logic [TAG_W-1:0]  dst_q     [N];
    logic [TAG_W-1:0]  dst_d     [N];
    logic [TAG_W-1:0]  s1_tag_q  [N];
    logic [TAG_W-1:0]  s1_tag_d  [N];
    logic [TAG_W-1:0]  s2_tag_q  [N];
    logic [TAG_W-1:0]  s2_tag_d  [N];
    logic [DATA_W-1:0] s1_val_q  [N];
    logic [DATA_W-1:0] s1_val_d  [N];
    logic [DATA_W-1:0] s2_val_q  [N];
    logic [DATA_W-1:0] s2_val_d  [N];

    logic              iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]   iss_op_q, iss_op_d;
    logic [TAG_W-1:0]  iss_dst_q, iss_dst_d;
    logic [DATA_W-1:0] iss_src1_q, iss_src1_d;
    logic [DATA_W-1:0] iss_src2_q, iss_src2_d;

    logic       slot_free;
    logic       grant_onehot;
    logic       grant_ok;
    logic [1:0] grant_idx;
    logic [1:0] free_idx;
    logic       free_found;
    logic [2:0] count_w;

    assign slot_free    = !iss_valid_q || iss_ready;
    assign req          = flush ? 4'b0000 : (valid_q & s1_rdy_q & s2_rdy_q & {4{slot_free}});
    assign disp_ready   = ~&valid_q;
    assign grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    // req already folds in slot availability and flush, so this single check covers both
    assign grant_ok     = grant_onehot && ((grant & req) != 4'b0000);

    always_comb begin
        grant_idx  = 2'd0;
        free_idx   = 2'd0;
        free_found = 1'b0;
        count_w    = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = 2'(i);
            if (!valid_q[i] && !free_found) begin
                free_idx   = 2'(i);
                free_found = 1'b1;
            end
            count_w = count_w + {2'b00, valid_q[i]};
        end
    end

    always_comb begin
        valid_d     = valid_q;
        s1_rdy_d    = s1_rdy_q;
        s2_rdy_d    = s2_rdy_q;
        op_d        = op_q;
        dst_d       = dst_q;
        s1_tag_d    = s1_tag_q;
        s2_tag_d    = s2_tag_q;
        s1_val_d    = s1_val_q;
        s2_val_d    = s2_val_q;
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_dst_d   = iss_dst_q;
        iss_src1_d  = iss_src1_q;
        iss_src2_d  = iss_src2_q;

        if (flush) begin
            valid_d     = '0;
            iss_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cdb_valid && valid_q[i] && !s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = cdb_value;
                end
                if (cdb_valid && valid_q[i] && !s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = cdb_value;
                end
            end

            if (grant_ok) begin
                iss_valid_d          = 1'b1;
                iss_op_d             = op_q[grant_idx];
                iss_dst_d            = dst_q[grant_idx];
                iss_src1_d           = s1_val_q[grant_idx];
                iss_src2_d           = s2_val_q[grant_idx];
                valid_d[grant_idx]   = 1'b0;
            end else if (iss_ready) begin
                iss_valid_d = 1'b0;
            end

            // free_idx comes from registered valids, so it never aliases the entry being issued
            if (disp_valid && disp_ready) begin
                valid_d[free_idx]  = 1'b1;
                op_d[free_idx]     = disp_op;
                dst_d[free_idx]    = disp_dst_tag;
                s1_tag_d[free_idx] = disp_src1_tag;
                s2_tag_d[free_idx] = disp_src2_tag;
                if (disp_src1_rdy) begin
                    s1_rdy_d[free_idx] = 1'b1;
                    s1_val_d[free_idx] = disp_src1_val;
                end else if (cdb_valid && cdb_tag == disp_src1_tag) begin
                    s1_rdy_d[free_idx] = 1'b1;
                    s1_val_d[free_idx] = cdb_value;
                end else begin
                    s1_rdy_d[free_idx] = 1'b0;
                end
                if (disp_src2_rdy) begin
                    s2_rdy_d[free_idx] = 1'b1;
                    s2_val_d[free_idx] = disp_src2_val;
                end else if (cdb_valid && cdb_tag == disp_src2_tag) begin
                    s2_rdy_d[free_idx] = 1'b1;
                    s2_val_d[free_idx] = cdb_value;
                end else begin
                    s2_rdy_d[free_idx] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q     <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_dst_q   <= '0;
            iss_src1_q  <= '0;
            iss_src2_q  <= '0;
            for (int i = 0; i < N; i++) begin
                op_q[i]     <= '0;
                dst_q[i]    <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_dst_q   <= iss_dst_d;
            iss_src1_q  <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;
            for (int i = 0; i < N; i++) begin
                op_q[i]     <= op_d[i];
                dst_q[i]    <= dst_d[i];
                s1_tag_q[i] <= s1_tag_d[i];
                s2_tag_q[i] <= s2_tag_d[i];
                s1_val_q[i] <= s1_val_d[i];
                s2_val_q[i] <= s2_val_d[i];
            end
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_op      = iss_op_q;
    assign iss_dst_tag = iss_dst_q;
    assign iss_src1    = iss_src1_q;
    assign iss_src2    = iss_src2_q;
    assign count       = count_w;

endmodule

// File: tb/tb_issue_station.sv
// Directed bench for issue_station: dispatch, wakeup, bypass, stall, illegal grants, flush, reset.
module tb_issue_station;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [7:0]  disp_op;
    logic [5:0]  disp_dst_tag;
    logic [5:0]  disp_src1_tag;
    logic        disp_src1_rdy;
    logic [31:0] disp_src1_val;
    logic [5:0]  disp_src2_tag;
    logic        disp_src2_rdy;
    logic [31:0] disp_src2_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        iss_valid;
    logic        iss_ready;
    logic [7:0]  iss_op;
    logic [5:0]  iss_dst_tag;
    logic [31:0] iss_src1;
    logic [31:0] iss_src2;
    logic [2:0]  count;

    int n_total = 0;
    int n_bad   = 0;

    issue_station #(.DATA_W(32), .TAG_W(6), .OP_W(8)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_op      (disp_op),
        .disp_dst_tag (disp_dst_tag),
        .disp_src1_tag(disp_src1_tag),
        .disp_src1_rdy(disp_src1_rdy),
        .disp_src1_val(disp_src1_val),
        .disp_src2_tag(disp_src2_tag),
        .disp_src2_rdy(disp_src2_rdy),
        .disp_src2_val(disp_src2_val),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .req          (req),
        .grant        (grant),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_op       (iss_op),
        .iss_dst_tag  (iss_dst_tag),
        .iss_src1     (iss_src1),
        .iss_src2     (iss_src2),
        .count        (count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; comb outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [7:0] op, input logic [5:0] dst,
                            input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2);
        disp_valid    = v;
        disp_op       = op;
        disp_dst_tag  = dst;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
    endtask

    initial begin
        RESET_N   = 1'b0;
        flush     = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_value = '0;
        grant     = 4'b0000;
        iss_ready = 1'b1;
        set_disp(1'b0, 8'h00, 6'd0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
        #3;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_req", 64'(req), 64'h0);
        check_eq("rst_iss_valid", 64'(iss_valid), 64'd0);
        check_eq("rst_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        RESET_N = 1'b1;

        // Fill all four entries with fully ready ops
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, 8'h10 + 8'(i), 6'(i + 1), 6'd40, 1'b1, 32'h100 + 32'(i),
                     6'd41, 1'b1, 32'h200 + 32'(i));
            tick();
        end
        disp_valid = 1'b0;
        #1;
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_disp_ready", 64'(disp_ready), 64'd0);
        check_eq("full_req", 64'(req), 64'hf);

        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("g0_iss_valid", 64'(iss_valid), 64'd1);
        check_eq("g0_iss_op", 64'(iss_op), 64'h10);
        check_eq("g0_iss_dst", 64'(iss_dst_tag), 64'd1);
        check_eq("g0_iss_src1", 64'(iss_src1), 64'h100);
        check_eq("g0_iss_src2", 64'(iss_src2), 64'h200);
        check_eq("g0_count", 64'(count), 64'd3);
        check_eq("g0_req", 64'(req), 64'he);

        // Functional unit stalls: slot holds and requests are suppressed
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("stall_req", 64'(req), 64'h0);
            check_eq("stall_op", 64'(iss_op), 64'h10);
            check_eq("stall_valid", 64'(iss_valid), 64'd1);
            tick();
        end
        iss_ready = 1'b1;
        grant     = 4'b0010;
        tick();
        #1;
        check_eq("b2b1_valid", 64'(iss_valid), 64'd1);
        check_eq("b2b1_op", 64'(iss_op), 64'h11);
        check_eq("b2b1_count", 64'(count), 64'd2);
        grant = 4'b0100;
        tick();
        #1;
        check_eq("b2b2_op", 64'(iss_op), 64'h12);
        grant = 4'b1000;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("b2b3_op", 64'(iss_op), 64'h13);
        check_eq("b2b3_count", 64'(count), 64'd0);
        tick();
        #1;
        check_eq("drain_valid", 64'(iss_valid), 64'd0);

        // Wakeup via CDB after dispatch
        set_disp(1'b1, 8'h20, 6'd7, 6'd5, 1'b0, 32'h0, 6'd6, 1'b1, 32'h55);
        tick();
        disp_valid = 1'b0;
        #1;
        check_eq("wait_req", 64'(req), 64'h0);
        check_eq("wait_count", 64'(count), 64'd1);

        // Illegal / unrequested grants are ignored
        grant = 4'b0110;
        tick();
        grant = 4'b1000;
        tick();
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("illegal_count", 64'(count), 64'd1);
        check_eq("illegal_iss_valid", 64'(iss_valid), 64'd0);

        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        cdb_value = 32'hDEADBEEF;
        #1;
        check_eq("no_fwd_req", 64'(req), 64'h0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check_eq("wake_req", 64'(req), 64'h1);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("wake_src1", 64'(iss_src1), 64'hDEADBEEF);
        check_eq("wake_src2", 64'(iss_src2), 64'h55);
        check_eq("wake_op", 64'(iss_op), 64'h20);
        tick();

        // Dispatch bypass from the CDB in the same cycle
        set_disp(1'b1, 8'h30, 6'd8, 6'd3, 1'b1, 32'h77, 6'd9, 1'b0, 32'h0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_value = 32'h1234;
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        #1;
        check_eq("byp_req", 64'(req), 64'h1);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("byp_src2", 64'(iss_src2), 64'h1234);
        check_eq("byp_src1", 64'(iss_src1), 64'h77);
        tick();

        // Same-cycle dispatch and issue
        set_disp(1'b1, 8'h40, 6'd10, 6'd0, 1'b1, 32'h400, 6'd0, 1'b1, 32'h401);
        tick();
        set_disp(1'b1, 8'h41, 6'd11, 6'd0, 1'b1, 32'h410, 6'd0, 1'b1, 32'h411);
        tick();
        set_disp(1'b1, 8'h42, 6'd12, 6'd0, 1'b1, 32'h420, 6'd0, 1'b1, 32'h421);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        #1;
        check_eq("dual_count", 64'(count), 64'd2);
        check_eq("dual_iss_op", 64'(iss_op), 64'h40);
        check_eq("dual_req", 64'(req), 64'h6);

        // Refill entry 0 while the slot is held, then flush against dispatch and grant
        iss_ready = 1'b0;
        set_disp(1'b1, 8'h43, 6'd13, 6'd0, 1'b1, 32'h430, 6'd0, 1'b1, 32'h431);
        tick();
        #1;
        check_eq("pre_flush_count", 64'(count), 64'd3);
        check_eq("pre_flush_valid", 64'(iss_valid), 64'd1);
        iss_ready = 1'b1;
        flush     = 1'b1;
        grant     = 4'b0010;
        #1;
        check_eq("flush_req", 64'(req), 64'h0);
        tick();
        flush      = 1'b0;
        grant      = 4'b0000;
        disp_valid = 1'b0;
        #1;
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_iss_valid", 64'(iss_valid), 64'd0);
        check_eq("flush_disp_ready", 64'(disp_ready), 64'd1);

        // Asynchronous reset mid-operation
        set_disp(1'b1, 8'h50, 6'd14, 6'd0, 1'b1, 32'h500, 6'd0, 1'b1, 32'h501);
        tick();
        set_disp(1'b1, 8'h51, 6'd15, 6'd0, 1'b1, 32'h510, 6'd0, 1'b1, 32'h511);
        grant = 4'b0001;
        tick();
        disp_valid = 1'b0;
        grant      = 4'b0000;
        iss_ready  = 1'b0;
        #1;
        check_eq("pre_rst_op", 64'(iss_op), 64'h50);
        RESET_N = 1'b0;
        #1;
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_req", 64'(req), 64'h0);
        check_eq("arst_iss_valid", 64'(iss_valid), 64'd0);
        check_eq("arst_iss_op", 64'(iss_op), 64'h0);
        check_eq("arst_iss_src1", 64'(iss_src1), 64'h0);
        check_eq("arst_disp_ready", 64'(disp_ready), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
